xenos_fault_manager: RTL and testbench
======================================

XENOS_FAULT_MANAGER -- requirements
Module: xenos_fault_manager

Interface
REQ-001 SHALL have parameter NUM_CH, default 12, number of monitored channels.
REQ-002 SHALL have parameter PERSIST, default 4 (range 1..15), consecutive fault cycles required to latch a channel.
REQ-003 SHALL have parameter SHUTDOWN_DLY, default 16 (range 1..255), cycles spent in ALERT before forced shutdown.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk (input, 1, rising-edge clock); rst (input, 1, synchronous active-high reset).
REQ-005 fault_in  input  NUM_CH  per-channel raw fault flag from the boundary checker.
REQ-006 code_in  input  [0:NUM_CH-1] x 4  per-channel fault code; bit0 over-volt, bit1 under-volt, bit2 over-current, bit3 over-temp.
REQ-007 clear_req  input  1  single-cycle clear request.
REQ-008 clear_mask  input  NUM_CH  channels targeted by clear_req.
REQ-009 clear_ack  output  1  one-cycle clear acknowledge.
REQ-010 latched_fault  output  NUM_CH  sticky per-channel fault.
REQ-011 latched_code  output  [0:NUM_CH-1] x 4  sticky OR-accumulated code per channel.
REQ-012 evt_valid / evt_ready  output / input  1 each  event stream handshake.
REQ-013 evt_channel  output  4  channel index of the presented event.
REQ-014 evt_code  output  4  latched_code of that channel, captured when the event is loaded.
REQ-015 state  output  2  FSM state: NORMAL=00, ALERT=01, SHUTDOWN=10.
REQ-016 power_enable  output  1  high unless state is SHUTDOWN.

Function
REQ-017 Each channel SHALL keep a saturating debounce counter: +1 (saturating at PERSIST) when fault_in[i]=1; cleared to 0 when fault_in[i]=0.
REQ-018 latched_fault[i] SHALL set at the clock edge that samples the PERSIST-th consecutive fault_in[i]=1 cycle; with PERSIST=1 it sets on the first sampled high cycle.
REQ-019 On every edge where latched_fault[i] sets or is already set and fault_in[i]=1, latched_code[i] SHALL be ORed with code_in[i]; bits SHALL never clear except by clear or reset.
REQ-020 A 0->1 transition of latched_fault[i] SHALL set pending[i] on the same edge.
REQ-021 The event register SHALL load the lowest-index pending channel when empty or when its current event transfers (evt_valid&&evt_ready) that cycle; loading clears that pending bit and captures evt_channel/evt_code.
REQ-022 evt_valid, evt_channel and evt_code SHALL remain stable while evt_valid=1 and evt_ready=0.
REQ-023 The earliest evt_valid SHALL be one cycle after latch; back-to-back transfers at one event per cycle SHALL be sustained when evt_ready=1.
REQ-024 Channels latching simultaneously SHALL be emitted in ascending index order.
REQ-025 FSM NORMAL->ALERT when any latched_fault bit is 1; ALERT counter cleared on entry.
REQ-026 ALERT->SHUTDOWN on the next edge when any latched_code bit3 is 1, or when the ALERT counter reaches SHUTDOWN_DLY-1.
REQ-027 ALERT->NORMAL when all latched_fault bits are 0; this takes priority over the timeout.
REQ-028 SHUTDOWN->NORMAL only when all latched_fault bits are 0.
REQ-029 On clear_req=1, each channel with clear_mask[i]=1, fault_in[i]=0 and counter=0 SHALL clear latched_fault[i], latched_code[i] and pending[i] at that edge; any other channel SHALL be unaffected.
REQ-030 clear_ack SHALL pulse high exactly one cycle after the clear_req cycle, regardless of how many channels cleared.
REQ-031 Clearing SHALL NOT alter an event already in the event register.
REQ-032 A clear and a latch on the same channel in the same cycle SHALL resolve to latched (this is guaranteed by REQ-029).

Reset
REQ-033 While rst=1, the block SHALL drive the following at the next edge: all counters 0, latched_fault=0, latched_code=0, pending=0, evt_valid=0, evt_channel=0, evt_code=0, clear_ack=0, state=NORMAL, power_enable=1.
REQ-034 Reset during ALERT or SHUTDOWN, or with an event stalled, SHALL discard all state with no event delivered.

Verification
REQ-035 fault_in[3]=1 for 3 cycles then 0 (PERSIST=4) -> no latch, state stays NORMAL, evt_valid stays 0.
REQ-036 fault_in[3]=1 for 4 cycles, code_in[3]=0001 -> latched_fault[3]=1, state=ALERT; next cycle evt_valid=1, evt_channel=3, evt_code=0001.
REQ-037 Channels 7 and 2 latch on the same edge with evt_ready=0 for 5 cycles, then 1 -> event 2 is held stable and transfers first, then event 7 on the next cycle.
REQ-038 Channel 0 latched with code_in[0]=0001, no further faults (SHUTDOWN_DLY=16) -> SHUTDOWN after 16 ALERT cycles and power_enable=0; clear_req with clear_mask bit0=1 -> clear_ack next cycle, state NORMAL, power_enable=1.
REQ-039 Channel 5 latched with code_in[5]=1000 -> ALERT then SHUTDOWN on the next edge.
REQ-040 clear_req with clear_mask=all ones while fault_in[1]=1 -> channel 1 stays latched, all other channels clear, clear_ack pulses once.

Source files
------------

// File: rtl/xenos_fault_manager_if.sv
// Bus bundle for xenos_fault_manager.
//   master : the environment (boundary checker, clear source, event sink)
//   slave  : the fault manager itself
// Signals: fault_in/code_in raw per-channel faults, clear_req/clear_mask/clear_ack
// clear handshake, latched_fault/latched_code sticky status, evt_* event stream
// (valid/ready), state FSM state, power_enable supply gate.
interface xenos_fault_manager_if #(
  parameter int NUM_CH = 12
);
  logic [NUM_CH-1:0]      fault_in;
  logic [0:NUM_CH-1][3:0] code_in;
  logic                   clear_req;
  logic [NUM_CH-1:0]      clear_mask;
  logic                   clear_ack;
  logic [NUM_CH-1:0]      latched_fault;
  logic [0:NUM_CH-1][3:0] latched_code;
  logic                   evt_valid;
  logic                   evt_ready;
  logic [3:0]             evt_channel;
  logic [3:0]             evt_code;
  logic [1:0]             state;
  logic                   power_enable;

  modport master (
    output fault_in, code_in, clear_req, clear_mask, evt_ready,
    input  clear_ack, latched_fault, latched_code, evt_valid, evt_channel,
           evt_code, state, power_enable
  );

  modport slave (
    input  fault_in, code_in, clear_req, clear_mask, evt_ready,
    output clear_ack, latched_fault, latched_code, evt_valid, evt_channel,
           evt_code, state, power_enable
  );
endinterface

// File: rtl/xenos_fault_manager.sv
// Fault manager: debounces NUM_CH raw fault flags, latches sticky faults and
// OR-accumulated codes, emits one event per newly latched channel (lowest
// index first) on a valid/ready stream, and runs a NORMAL/ALERT/SHUTDOWN FSM
// that gates power_enable.
// Ports: clk, rst (sync, active high), bus (xenos_fault_manager_if.slave).

// Per-channel debounce / latch / pending slice.
//   clr      : clear_req && clear_mask[i]
//   ld       : this channel's pending event is being loaded into the event reg
//   lat_nxt / lcode_nxt expose the values being registered this edge so the
//   FSM reacts on the same edge a channel latches or clears.
module xenos_fm_chan #(
  parameter int PERSIST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fault,
  input  logic [3:0] code,
  input  logic       clr,
  input  logic       ld,
  output logic       lat,
  output logic [3:0] lcode,
  output logic       pend,
  output logic       lat_nxt,
  output logic [3:0] lcode_nxt
);
  localparam logic [3:0] P = 4'(PERSIST);

  logic [3:0] cnt, cnt_nxt;
  logic       hit, clr_ok, pend_nxt;

  always_comb begin
    cnt_nxt = '0;
    if (fault) cnt_nxt = (cnt == P) ? P : cnt + 4'd1;
    hit       = fault && (cnt_nxt == P);
    // A clear only wins on a quiet channel, so clear-vs-latch resolves to latched.
    clr_ok    = clr && !fault && (cnt == '0);
    lat_nxt   = lat;
    lcode_nxt = lcode;
    pend_nxt  = pend;
    if (ld)          pend_nxt = 1'b0;
    if (hit && !lat) pend_nxt = 1'b1;
    if (hit)         lat_nxt  = 1'b1;
    if (fault && lat_nxt) lcode_nxt = lcode | code;
    if (clr_ok) begin
      lat_nxt   = 1'b0;
      lcode_nxt = '0;
      pend_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      lat   <= 1'b0;
      lcode <= '0;
      pend  <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      lat   <= lat_nxt;
      lcode <= lcode_nxt;
      pend  <= pend_nxt;
    end
  end
endmodule

module xenos_fault_manager #(
  parameter int NUM_CH       = 12,
  parameter int PERSIST      = 4,
  parameter int SHUTDOWN_DLY = 16
) (
  input logic                  clk,
  input logic                  rst,
  xenos_fault_manager_if.slave bus
);
  typedef enum logic [1:0] {
    NORMAL   = 2'b00,
    ALERT    = 2'b01,
    SHUTDOWN = 2'b10
  } state_e;

  localparam logic [7:0] DLY_LAST = 8'(SHUTDOWN_DLY - 1);

  logic [NUM_CH-1:0]      lat, lat_nxt, pend, ld;
  logic [0:NUM_CH-1][3:0] lcode, lcode_nxt;
  logic [3:0]             sel, sel_code;
  logic                   load;
  logic                   evt_valid;
  logic [3:0]             evt_channel, evt_code;
  logic                   ack_q;
  logic                   any_lat, any_ot;
  state_e                 state_q, state_nxt;
  logic [7:0]             acnt, acnt_nxt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    xenos_fm_chan #(.PERSIST(PERSIST)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .fault     (bus.fault_in[i]),
      .code      (bus.code_in[i]),
      .clr       (bus.clear_req && bus.clear_mask[i]),
      .ld        (ld[i]),
      .lat       (lat[i]),
      .lcode     (lcode[i]),
      .pend      (pend[i]),
      .lat_nxt   (lat_nxt[i]),
      .lcode_nxt (lcode_nxt[i])
    );
    assign ld[i] = load && (sel == 4'(i));
  end

  // Lowest-index pending channel; descending scan so the lowest hit wins.
  always_comb begin
    sel      = '0;
    sel_code = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel      = 4'(i);
        sel_code = lcode[i];
      end
    end
  end

  // Reload on the transfer cycle keeps one event per cycle under evt_ready=1.
  assign load = (|pend) && (!evt_valid || bus.evt_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid   <= 1'b0;
      evt_channel <= '0;
      evt_code    <= '0;
      ack_q       <= 1'b0;
    end else begin
      ack_q <= bus.clear_req;
      if (load) begin
        evt_valid   <= 1'b1;
        evt_channel <= sel;
        evt_code    <= sel_code;
      end else if (bus.evt_ready) begin
        evt_valid   <= 1'b0;
      end
    end
  end

  // FSM looks at the post-edge latch status so a latch or clear moves the
  // state on the same edge.
  always_comb begin
    any_lat = |lat_nxt;
    any_ot  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) any_ot = any_ot | lcode_nxt[i][3];
  end

  always_comb begin
    state_nxt = state_q;
    acnt_nxt  = acnt;
    case (state_q)
      NORMAL: begin
        if (any_lat) begin
          state_nxt = ALERT;
          acnt_nxt  = '0;
        end
      end
      ALERT: begin
        if (!any_lat)                          state_nxt = NORMAL;
        else if (any_ot || acnt == DLY_LAST)   state_nxt = SHUTDOWN;
        else                                   acnt_nxt  = acnt + 8'd1;
      end
      SHUTDOWN: begin
        if (!any_lat) state_nxt = NORMAL;
      end
      default: state_nxt = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NORMAL;
      acnt    <= '0;
    end else begin
      state_q <= state_nxt;
      acnt    <= acnt_nxt;
    end
  end

  assign bus.latched_fault = lat;
  assign bus.latched_code  = lcode;
  assign bus.evt_valid     = evt_valid;
  assign bus.evt_channel   = evt_channel;
  assign bus.evt_code      = evt_code;
  assign bus.clear_ack     = ack_q;
  assign bus.state         = state_q;
  assign bus.power_enable  = (state_q != SHUTDOWN);
endmodule

// File: tb/tb_xenos_fault_manager.sv
module tb_xenos_fault_manager;
  localparam int NC  = 12;
  localparam int P   = 4;
  localparam int DLY = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xenos_fault_manager_if #(.NUM_CH(NC)) bus();
  xenos_fault_manager #(.NUM_CH(NC), .PERSIST(P), .SHUTDOWN_DLY(DLY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: run lengths as plain integers, event slot as a record,
  // ALERT tracked as number of cycles spent there.
  int                     run [NC];
  logic [NC-1:0]          m_lat, m_pend;
  logic [0:NC-1][3:0]     m_code;
  logic                   m_v, m_ack;
  logic [3:0]             m_ch, m_ec;
  int                     m_st, age;

  typedef struct {
    logic [11:0] f;
    logic [3:0]  c3;
    logic        clr;
    logic [11:0] mask;
    logic [11:0] e_lat;
    logic [1:0]  e_st;
    logic        e_v;
    logic [3:0]  e_ch;
    logic [3:0]  e_code;
    logic        e_ack;
  } vec_t;
  vec_t tv [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mdl_update();
    logic any, ot, elig;
    if (rst) begin
      for (int i = 0; i < NC; i++) run[i] = 0;
      m_lat = '0; m_pend = '0; m_code = '0;
      m_v = 1'b0; m_ch = '0; m_ec = '0; m_ack = 1'b0;
      m_st = 0; age = 0;
      return;
    end
    m_ack = bus.clear_req;
    // event slot sees pending/codes from before this edge
    if (m_v && bus.evt_ready) m_v = 1'b0;
    if (!m_v) begin
      for (int i = 0; i < NC; i++) begin
        if (m_pend[i]) begin
          m_v = 1'b1; m_ch = 4'(i); m_ec = m_code[i]; m_pend[i] = 1'b0;
          break;
        end
      end
    end
    for (int i = 0; i < NC; i++) begin
      elig = bus.clear_req && bus.clear_mask[i] && !bus.fault_in[i] && run[i] == 0;
      run[i] = bus.fault_in[i] ? (run[i] < 100 ? run[i] + 1 : run[i]) : 0;
      if (elig) begin
        m_lat[i] = 1'b0; m_code[i] = '0; m_pend[i] = 1'b0;
      end else if (bus.fault_in[i]) begin
        if (run[i] >= P && !m_lat[i]) begin
          m_lat[i] = 1'b1; m_pend[i] = 1'b1;
        end
        if (m_lat[i]) m_code[i] = m_code[i] | bus.code_in[i];
      end
    end
    any = |m_lat;
    ot  = 1'b0;
    for (int i = 0; i < NC; i++) ot = ot | m_code[i][3];
    case (m_st)
      0: if (any) begin m_st = 1; age = 1; end
      1: begin
        if (!any)                    m_st = 0;
        else if (ot || age >= DLY)   m_st = 2;
        else                         age++;
      end
      default: if (!any) m_st = 0;
    endcase
  endtask

  task automatic mdl_cmp();
    chk("mdl_latched_fault", 64'(bus.latched_fault), 64'(m_lat));
    chk("mdl_latched_code", 64'(bus.latched_code), 64'(m_code));
    chk("mdl_evt_valid", 64'(bus.evt_valid), 64'(m_v));
    if (m_v) begin
      chk("mdl_evt_channel", 64'(bus.evt_channel), 64'(m_ch));
      chk("mdl_evt_code", 64'(bus.evt_code), 64'(m_ec));
    end
    chk("mdl_state", 64'(bus.state), 64'(m_st));
    chk("mdl_power_enable", 64'(bus.power_enable), 64'(m_st != 2));
    chk("mdl_clear_ack", 64'(bus.clear_ack), 64'(m_ack));
  endtask

  // One clock: inputs set beforehand are sampled at the edge, outputs read #1 later.
  task automatic cyc();
    @(posedge clk);
    #1;
    mdl_update();
    mdl_cmp();
  endtask

  task automatic idle();
    bus.fault_in   = '0;
    bus.code_in    = '0;
    bus.clear_req  = 1'b0;
    bus.clear_mask = '0;
    bus.evt_ready  = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    tv[0]  = '{12'h008, 4'h1, 1'b0, 12'h000, 12'h000, 2'd0, 1'b0, 4'd0, 4'h0, 1'b0};
    tv[1]  = '{12'h008, 4'h1, 1'b0, 12'h000, 12'h000, 2'd0, 1'b0, 4'd0, 4'h0, 1'b0};
    tv[2]  = '{12'h008, 4'h1, 1'b0, 12'h000, 12'h000, 2'd0, 1'b0, 4'd0, 4'h0, 1'b0};
    tv[3]  = '{12'h000, 4'h0, 1'b0, 12'h000, 12'h000, 2'd0, 1'b0, 4'd0, 4'h0, 1'b0};
    tv[4]  = '{12'h008, 4'h1, 1'b0, 12'h000, 12'h000, 2'd0, 1'b0, 4'd0, 4'h0, 1'b0};
    tv[5]  = '{12'h008, 4'h1, 1'b0, 12'h000, 12'h000, 2'd0, 1'b0, 4'd0, 4'h0, 1'b0};
    tv[6]  = '{12'h008, 4'h1, 1'b0, 12'h000, 12'h000, 2'd0, 1'b0, 4'd0, 4'h0, 1'b0};
    tv[7]  = '{12'h008, 4'h1, 1'b0, 12'h000, 12'h008, 2'd1, 1'b0, 4'd0, 4'h0, 1'b0};
    tv[8]  = '{12'h000, 4'h0, 1'b0, 12'h000, 12'h008, 2'd1, 1'b1, 4'd3, 4'h1, 1'b0};
    tv[9]  = '{12'h000, 4'h0, 1'b0, 12'h000, 12'h008, 2'd1, 1'b0, 4'd0, 4'h0, 1'b0};
    tv[10] = '{12'h000, 4'h0, 1'b1, 12'h008, 12'h000, 2'd0, 1'b0, 4'd0, 4'h0, 1'b1};
    tv[11] = '{12'h000, 4'h0, 1'b0, 12'h000, 12'h000, 2'd0, 1'b0, 4'd0, 4'h0, 1'b0};

    rst = 1'b1;
    do_reset();
    chk("reset_latched", 64'(bus.latched_fault), 64'd0);
    chk("reset_evt_valid", 64'(bus.evt_valid), 64'd0);
    chk("reset_state", 64'(bus.state), 64'd0);
    chk("reset_power", 64'(bus.power_enable), 64'd1);
    chk("reset_ack", 64'(bus.clear_ack), 64'd0);

    // short burst, full debounce, event, clear
    for (int k = 0; k < 12; k++) begin
      bus.fault_in   = tv[k].f;
      bus.code_in[3] = tv[k].c3;
      bus.clear_req  = tv[k].clr;
      bus.clear_mask = tv[k].mask;
      cyc();
      chk($sformatf("tv%0d_latched", k), 64'(bus.latched_fault), 64'(tv[k].e_lat));
      chk($sformatf("tv%0d_state", k), 64'(bus.state), 64'(tv[k].e_st));
      chk($sformatf("tv%0d_evt_valid", k), 64'(bus.evt_valid), 64'(tv[k].e_v));
      if (tv[k].e_v) begin
        chk($sformatf("tv%0d_evt_channel", k), 64'(bus.evt_channel), 64'(tv[k].e_ch));
        chk($sformatf("tv%0d_evt_code", k), 64'(bus.evt_code), 64'(tv[k].e_code));
      end
      chk($sformatf("tv%0d_ack", k), 64'(bus.clear_ack), 64'(tv[k].e_ack));
    end

    // simultaneous latch on 7 and 2 with a stalled sink
    do_reset();
    bus.evt_ready = 1'b0;
    bus.fault_in[7] = 1'b1; bus.code_in[7] = 4'b0010;
    bus.fault_in[2] = 1'b1; bus.code_in[2] = 4'b0100;
    repeat (4) cyc();
    chk("dual_latched", 64'(bus.latched_fault), 64'h084);
    bus.fault_in = '0;
    cyc();
    chk("dual_first_valid", 64'(bus.evt_valid), 64'd1);
    chk("dual_first_code", 64'(bus.evt_code), 64'h4);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("dual_hold_valid", 64'(bus.evt_valid), 64'd1);
      chk("dual_hold_channel", 64'(bus.evt_channel), 64'd2);
    end
    bus.evt_ready = 1'b1;
    cyc();
    chk("dual_second_valid", 64'(bus.evt_valid), 64'd1);
    chk("dual_second_channel", 64'(bus.evt_channel), 64'd7);
    chk("dual_second_code", 64'(bus.evt_code), 64'h2);
    cyc();
    chk("dual_drained", 64'(bus.evt_valid), 64'd0);

    // over-temperature: ALERT then SHUTDOWN on the next edge
    do_reset();
    bus.fault_in[5] = 1'b1; bus.code_in[5] = 4'b1000;
    repeat (4) cyc();
    chk("ot_alert", 64'(bus.state), 64'd1);
    bus.fault_in = '0;
    cyc();
    chk("ot_shutdown", 64'(bus.state), 64'd2);
    chk("ot_power_off", 64'(bus.power_enable), 64'd0);

    // timeout after SHUTDOWN_DLY cycles in ALERT, then clear
    do_reset();
    bus.fault_in[0] = 1'b1; bus.code_in[0] = 4'b0001;
    repeat (4) cyc();
    chk("to_alert_entry", 64'(bus.state), 64'd1);
    bus.fault_in = '0;
    for (int k = 0; k < DLY - 1; k++) begin
      cyc();
      chk("to_still_alert", 64'(bus.state), 64'd1);
    end
    cyc();
    chk("to_shutdown", 64'(bus.state), 64'd2);
    chk("to_power_off", 64'(bus.power_enable), 64'd0);
    bus.clear_req = 1'b1; bus.clear_mask = 12'h001;
    cyc();
    bus.clear_req = 1'b0; bus.clear_mask = '0;
    chk("to_clear_ack", 64'(bus.clear_ack), 64'd1);
    chk("to_clear_state", 64'(bus.state), 64'd0);
    chk("to_clear_power", 64'(bus.power_enable), 64'd1);
    cyc();
    chk("to_ack_drop", 64'(bus.clear_ack), 64'd0);

    // clear-all while channel 1 is still faulting
    do_reset();
    bus.fault_in[1] = 1'b1; bus.code_in[1] = 4'b0011;
    bus.fault_in[4] = 1'b1; bus.code_in[4] = 4'b0011;
    repeat (4) cyc();
    bus.fault_in[4] = 1'b0;
    repeat (2) cyc();
    bus.clear_req = 1'b1; bus.clear_mask = '1;
    cyc();
    bus.clear_req = 1'b0; bus.clear_mask = '0;
    chk("clrall_latched", 64'(bus.latched_fault), 64'h002);
    chk("clrall_ack", 64'(bus.clear_ack), 64'd1);
    cyc();
    chk("clrall_ack_once", 64'(bus.clear_ack), 64'd0);
    chk("clrall_keep_code", 64'(bus.latched_code[1]), 64'h3);

    // reset with an event stalled discards it
    do_reset();
    bus.evt_ready = 1'b0;
    bus.fault_in[9] = 1'b1;
    repeat (4) cyc();
    bus.fault_in = '0;
    repeat (3) cyc();
    chk("rststall_valid_before", 64'(bus.evt_valid), 64'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rststall_valid", 64'(bus.evt_valid), 64'd0);
    chk("rststall_latched", 64'(bus.latched_fault), 64'd0);
    chk("rststall_state", 64'(bus.state), 64'd0);
    bus.evt_ready = 1'b1;
    repeat (3) cyc();
    chk("rststall_no_event", 64'(bus.evt_valid), 64'd0);

    // random traffic against the model (checked inside cyc)
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NC; i++) begin
        if (bus.fault_in[i]) begin
          if ($urandom_range(0, 5) == 0) bus.fault_in[i] = 1'b0;
        end else begin
          if ($urandom_range(0, 11) == 0) bus.fault_in[i] = 1'b1;
        end
        bus.code_in[i] = 4'($urandom_range(0, 7)) | (($urandom_range(0, 15) == 0) ? 4'h8 : 4'h0);
      end
      bus.clear_req  = ($urandom_range(0, 5) == 0);
      bus.clear_mask = 12'($urandom);
      bus.evt_ready  = ($urandom_range(0, 2) != 0);
      rst            = ($urandom_range(0, 399) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
